// File: rtl/seq_multiplier_pkg.sv
// Shared definitions for the shift-add multiplier: FSM state type and
// the sizing helper for the iteration counter.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/busy/done handshake and operand/product bus of the multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 4
);
  logic                 start;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 is_signed;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   p;

  modport master (
    output start, a, b, is_signed,
    input  busy, done, p
  );

  modport slave (
    input  start, a, b, is_signed,
    output busy, done, p
  );
endinterface

// File: rtl/seq_multiplier_sign_mag.sv
// Conditional two's-complement negate, used both to take operand
// magnitudes and to restore the sign of the final product.
module mult_sign_mag #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  input  logic             neg,
  output logic [WIDTH-1:0] out
);
  assign out = neg ? (~in + 1'b1) : in;
endmodule

// File: rtl/seq_multiplier.sv
// Multi-cycle shift-add multiplier, WIDTH x WIDTH -> 2*WIDTH, with optional
// two's-complement mode handled by sign/magnitude conversion around the core.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit SIGNED_EN = 1'b1
) (
  input logic             clk,
  input logic             rst,
  seq_multiplier_if.slave bus
);
  localparam int CW = clog2(WIDTH + 1);

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     mcand_q, mcand_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic                 neg_q, neg_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic                 signed_op;
  logic [WIDTH-1:0]     mag_a, mag_b;
  logic [WIDTH:0]       sum;
  logic [2*WIDTH-1:0]   acc_step;
  logic [2*WIDTH-1:0]   prod_fix;

  assign signed_op = SIGNED_EN && bus.is_signed;

  // Add into the upper half with the carry kept, then shift right by one.
  assign sum      = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
  assign acc_step = {sum, acc_q[WIDTH-1:1]};

  generate
    if (SIGNED_EN) begin : g_signed
      mult_sign_mag #(.WIDTH(WIDTH)) u_mag_a (
        .in (bus.a),
        .neg(signed_op & bus.a[WIDTH-1]),
        .out(mag_a)
      );
      mult_sign_mag #(.WIDTH(WIDTH)) u_mag_b (
        .in (bus.b),
        .neg(signed_op & bus.b[WIDTH-1]),
        .out(mag_b)
      );
      mult_sign_mag #(.WIDTH(2*WIDTH)) u_fix (
        .in (acc_step),
        .neg(neg_q),
        .out(prod_fix)
      );
    end else begin : g_unsigned
      assign mag_a    = bus.a;
      assign mag_b    = bus.b;
      assign prod_fix = acc_step;
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    neg_d    = neg_q;
    cnt_d    = cnt_q;

    case (state_q)
      ST_IDLE: ;
      ST_RUN: begin
        acc_d    = acc_step;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // The product is corrected and published on the same edge that enters DONE.
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
          p_d     = prod_fix;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if ((state_q != ST_RUN) && bus.start) begin
      state_d  = ST_RUN;
      mcand_d  = mag_a;
      mplier_d = mag_b;
      neg_d    = signed_op & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
      acc_d    = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      neg_q    <= neg_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.busy = (state_q == ST_RUN);
  assign bus.done = (state_q == ST_DONE);
  assign bus.p    = p_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Self-checking bench for seq_multiplier: directed table, handshake corner
// cases and a randomized sweep against an arithmetic reference product.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seq_multiplier_if #(.WIDTH(4))  if4 ();
  seq_multiplier_if #(.WIDTH(8))  if8 ();
  seq_multiplier_if #(.WIDTH(16)) if16 ();

  seq_multiplier #(.WIDTH(4),  .SIGNED_EN(1'b1)) dut4  (.clk(clk), .rst(rst), .bus(if4.slave));
  seq_multiplier #(.WIDTH(8),  .SIGNED_EN(1'b0)) dut8  (.clk(clk), .rst(rst), .bus(if8.slave));
  seq_multiplier #(.WIDTH(16), .SIGNED_EN(1'b1)) dut16 (.clk(clk), .rst(rst), .bus(if16.slave));

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: full-precision integer product reduced modulo 2^(2w).
  function automatic longint unsigned ref_mul(input int w, input longint unsigned a,
                                              input longint unsigned b, input bit s);
    longint sa, sb, prod;
    sa = longint'(a);
    sb = longint'(b);
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    prod = sa * sb;
    return longint'(prod) & ((longint'(1) << (2 * w)) - 1);
  endfunction

  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic s,
                     output longint unsigned p, output int lat, output bit held);
    logic [7:0] p_prev;
    p_prev = if4.p;
    held = 1'b1;
    if4.a = a; if4.b = b; if4.is_signed = s; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = 0;
    while (!if4.done && lat < 50) begin
      if (if4.p !== p_prev) held = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    p = 64'(if4.p);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s,
                     output longint unsigned p, output int lat);
    if8.a = a; if8.b = b; if8.is_signed = s; if8.start = 1'b1;
    @(posedge clk); #1;
    if8.start = 1'b0;
    lat = 0;
    while (!if8.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = 64'(if8.p);
  endtask

  task automatic op16(input logic [15:0] a, input logic [15:0] b, input logic s,
                      output longint unsigned p, output int lat);
    if16.a = a; if16.b = b; if16.is_signed = s; if16.start = 1'b1;
    @(posedge clk); #1;
    if16.start = 1'b0;
    lat = 0;
    while (!if16.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    p = 64'(if16.p);
  endtask

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic       s;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[10];

  initial begin
    longint unsigned p;
    int lat;
    bit held;
    bit seen_done;
    int done_at[$];

    vecs[0] = '{4'h2, 4'h4, 1'b0, 8'h08};
    vecs[1] = '{4'hA, 4'hB, 1'b0, 8'h6E};
    vecs[2] = '{4'hF, 4'hD, 1'b0, 8'hC3};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 8'hE1};
    vecs[4] = '{4'hD, 4'h5, 1'b1, 8'hF1};
    vecs[5] = '{4'h8, 4'h8, 1'b1, 8'h40};
    vecs[6] = '{4'h8, 4'h7, 1'b1, 8'hC8};
    vecs[7] = '{4'h7, 4'h7, 1'b1, 8'h31};
    vecs[8] = '{4'hD, 4'h5, 1'b0, 8'h41};
    vecs[9] = '{4'h0, 4'h9, 1'b1, 8'h00};

    if4.start = 0;  if4.a = 0;  if4.b = 0;  if4.is_signed = 0;
    if8.start = 0;  if8.a = 0;  if8.b = 0;  if8.is_signed = 0;
    if16.start = 0; if16.a = 0; if16.b = 0; if16.is_signed = 0;

    // Reset and idle state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_busy", 64'(if4.busy), 0);
    chk("reset_done", 64'(if4.done), 0);
    chk("reset_p", 64'(if4.p), 0);
    rst = 1'b0;

    // Reset in the middle of an operation discards it
    if4.a = 4'h7; if4.b = 4'h7; if4.is_signed = 1'b0; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    @(posedge clk); #1;
    chk("midrun_busy_before", 64'(if4.busy), 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrun_busy_after", 64'(if4.busy), 0);
    chk("midrun_p_after", 64'(if4.p), 0);
    seen_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (if4.done) seen_done = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrun_no_done", 64'(seen_done), 0);

    // Directed table
    foreach (vecs[i]) begin
      op4(vecs[i].a, vecs[i].b, vecs[i].s, p, lat, held);
      chk($sformatf("vec%0d_p", i), p, 64'(vecs[i].exp));
      chk($sformatf("vec%0d_latency", i), 64'(lat), 4);
      chk($sformatf("vec%0d_p_held", i), 64'(held), 1);
    end
    @(posedge clk); #1;

    // Start held high: back-to-back operations, one done every 5 cycles
    if4.a = 4'h3; if4.b = 4'h5; if4.is_signed = 1'b0; if4.start = 1'b1;
    for (int e = 1; e <= 15; e++) begin
      @(posedge clk); #1;
      if (if4.done) begin
        done_at.push_back(e);
        chk("b2b_p", 64'(if4.p), 64'h0F);
      end
    end
    if4.start = 1'b0;
    chk("b2b_done_count", 64'(done_at.size()), 3);
    if (done_at.size() == 3) begin
      chk("b2b_first_done", 64'(done_at[0]), 5);
      chk("b2b_spacing1", 64'(done_at[1] - done_at[0]), 5);
      chk("b2b_spacing2", 64'(done_at[2] - done_at[1]), 5);
    end
    @(posedge clk); #1;

    // Start pulse and operand changes during RUN are ignored
    if4.a = 4'h6; if4.b = 4'h7; if4.is_signed = 1'b0; if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0; if4.a = 4'h1; if4.b = 4'h1; if4.is_signed = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b1;
    @(posedge clk); #1;
    if4.start = 1'b0;
    lat = 2;
    while (!if4.done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("run_ignore_p", 64'(if4.p), 64'h2A);
    chk("run_ignore_latency", 64'(lat), 4);
    @(posedge clk); #1;
    chk("run_ignore_idle_after", 64'(if4.busy | if4.done), 0);

    // Sign logic removed: is_signed ignored
    op8(8'hFF, 8'hFF, 1'b1, p, lat);
    chk("nosign_p", p, 64'hFE01);
    chk("nosign_latency", 64'(lat), 8);

    // Randomized sweep
    for (int i = 0; i < 400; i++) begin
      logic [3:0] ra, rb;
      logic rs;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      rs = 1'($urandom_range(0, 1));
      op4(ra, rb, rs, p, lat, held);
      chk("rand4_p", p, ref_mul(4, 64'(ra), 64'(rb), rs));
      chk("rand4_latency", 64'(lat), 4);
    end
    for (int i = 0; i < 300; i++) begin
      logic [7:0] ra, rb;
      logic rs;
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom_range(0, 1));
      op8(ra, rb, rs, p, lat);
      chk("rand8_p", p, ref_mul(8, 64'(ra), 64'(rb), 1'b0));
      chk("rand8_latency", 64'(lat), 8);
    end
    for (int i = 0; i < 300; i++) begin
      logic [15:0] ra, rb;
      logic rs;
      ra = 16'($urandom);
      rb = 16'($urandom);
      rs = 1'($urandom_range(0, 1));
      if (i == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
      op16(ra, rb, rs, p, lat);
      chk("rand16_p", p, ref_mul(16, 64'(ra), 64'(rb), rs));
      chk("rand16_latency", 64'(lat), 16);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
